// File: rtl/main_control_fsm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// main_control_fsm_pkg : opcodes, ALUOp/PCSrc encodings, state enum, controls
// Rev 1.0
// ---------------------------------------------------------------------------
package main_control_fsm_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_WB_R    = 4'd4,
    S_EXEC_I  = 4'd5,
    S_WB_I    = 4'd6,
    S_MEMADDR = 4'd7,
    S_MEM_RD  = 4'd8,
    S_MEM_WR  = 4'd9,
    S_WB_LW   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_TRAP    = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
  } ctrl_t;

  // States that wait on mem_ack and therefore run the timeout counter
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/main_control_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// main_control_fsm_if : controller <-> datapath/memory control bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface main_control_fsm_if;
  logic       run;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ack;
  logic [1:0] ALUOp;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic       IorD;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic       illegal_op;
  logic       bus_err;
  logic [3:0] state_o;

  modport master (
    input  run, opcode, zero, mem_ack,
    output ALUOp, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           IorD, IRWrite, PCWrite, PCSrc, illegal_op, bus_err, state_o
  );

  modport slave (
    output run, opcode, zero, mem_ack,
    input  ALUOp, RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
           IorD, IRWrite, PCWrite, PCSrc, illegal_op, bus_err, state_o
  );
endinterface
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// main_control_fsm : multi-cycle FETCH/DECODE/EXEC/MEM/WB main controller
// Rev 1.0
// ---------------------------------------------------------------------------
module main_control_fsm
  import main_control_fsm_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  main_control_fsm_if.master bus
);

  state_t           r_state;
  state_t           w_next;
  state_t           w_ret;
  logic [CNT_W-1:0] r_cnt;
  logic             r_is_sw;
  logic             r_illegal;
  logic             r_bus_err;
  logic             w_in_mem;
  logic             w_timeout;
  logic             w_decode_bad;
  ctrl_t            w_ctrl;

  assign w_in_mem  = is_mem_state(r_state);
  // A mem_ack arriving in the timeout cycle still completes the access
  assign w_timeout = w_in_mem && !bus.mem_ack && (r_cnt == CNT_W'(MEM_TIMEOUT));
  assign w_ret     = bus.run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_decode_bad = 1'b0;
    case (r_state)
      S_IDLE:    if (bus.run) w_next = S_FETCH;
      S_FETCH: begin
        if (bus.mem_ack)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     w_next = S_EXEC_R;
          OP_LW, OP_SW: w_next = S_MEMADDR;
          OP_ADDI:      w_next = S_EXEC_I;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next       = S_TRAP;
            w_decode_bad = 1'b1;
          end
        endcase
      end
      S_EXEC_R:  w_next = S_WB_R;
      S_WB_R:    w_next = w_ret;
      S_EXEC_I:  w_next = S_WB_I;
      S_WB_I:    w_next = w_ret;
      S_MEMADDR: w_next = r_is_sw ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (bus.mem_ack)    w_next = S_WB_LW;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_MEM_WR: begin
        if (bus.mem_ack)    w_next = w_ret;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_WB_LW:   w_next = w_ret;
      S_BRANCH:  w_next = w_ret;
      S_JUMP:    w_next = w_ret;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (w_in_mem && !bus.mem_ack && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // MEMADDR needs lw/sw after DECODE has moved on, so the choice is kept here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_sw   <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      if (r_state == S_DECODE) r_is_sw <= (bus.opcode == OP_SW);
      if (w_decode_bad)        r_illegal <= 1'b1;
      if (w_timeout)           r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.alu_op   = ALUOP_ADD;
        if (bus.mem_ack) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src   = PCSRC_SEQ;
        end
      end
      S_EXEC_R:  w_ctrl.alu_op = ALUOP_RTYPE;
      S_WB_R: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_I:  w_ctrl.alu_src = 1'b1;
      S_WB_I:    w_ctrl.reg_write = 1'b1;
      S_MEMADDR: w_ctrl.alu_src = 1'b1;
      S_MEM_RD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.i_or_d    = 1'b1;
      end
      S_WB_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alu_op   = ALUOP_SUB;
        w_ctrl.pc_src   = PCSRC_BRANCH;
        w_ctrl.pc_write = bus.zero;
      end
      S_JUMP: begin
        w_ctrl.pc_write = 1'b1;
        w_ctrl.pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.ALUOp      = w_ctrl.alu_op;
  assign bus.RegDst     = w_ctrl.reg_dst;
  assign bus.ALUSrc     = w_ctrl.alu_src;
  assign bus.MemtoReg   = w_ctrl.mem_to_reg;
  assign bus.RegWrite   = w_ctrl.reg_write;
  assign bus.MemRead    = w_ctrl.mem_read;
  assign bus.MemWrite   = w_ctrl.mem_write;
  assign bus.IorD       = w_ctrl.i_or_d;
  assign bus.IRWrite    = w_ctrl.ir_write;
  assign bus.PCWrite    = w_ctrl.pc_write;
  assign bus.PCSrc      = w_ctrl.pc_src;
  assign bus.illegal_op = r_illegal;
  assign bus.bus_err    = r_bus_err;
  assign bus.state_o    = r_state;

endmodule
`default_nettype wire
